multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the multicycle variant of the RV32I core. It sequences one instruction over 3–5 cycles by driving the shared datapath muxes: the 3-input ALU source selects, the result select, and the address select. It also drives the architectural write enables. Sits beside the ALU decoder; consumes op from the instruction register and zero from the ALU, and waits on a memory ready handshake.

Parameters:
USE_READY, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = mem_ready ignored (treated as 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; state <= FETCH on the edge where reset=1
op  input  7  instr[6:0] from the instruction register
zero  input  1  ALU zero flag (valid in BEQ state)
mem_ready  input  1  memory has completed the current access this cycle
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0 = PC, 1 = result
mem_write  output  1  data memory write strobe
ir_write  output  1  instruction register / OldPC enable
result_src  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  SrcA mux select: 00 PC, 01 OldPC, 10 A (rs1)
alu_src_b  output  2  SrcB mux select: 00 WriteData (rs2), 01 ImmExt, 10 constant 4
alu_op  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
reg_write  output  1  register file write enable
illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- State is a 4-bit register. Outputs are decoded combinationally from state (Moore), except for the gating listed below. Any unlisted output in a state is 0.
- Gating:
  - pc_write = (pc_update & rdy) | (branch & zero), where rdy = mem_ready | ~USE_READY.
  - ir_write = FETCH & rdy.
  - mem_write = MEMWRITE (asserted every cycle of the hold).
  - While reset=1, pc_write, ir_write, mem_write and reg_write are forced to 0.
- Reset: the first cycle after reset deasserts is FETCH. At reset the selects show FETCH values: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. illegal_op=0.
- FETCH: adr_src=0, ir_write, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update. Goes to DECODE when rdy, else stays in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Goes to MEMWB when rdy, else stays.
- MEMWB: result_src=01, reg_write. Next is FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write. Goes to FETCH when rdy, else stays.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write. Next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update (not gated by rdy). Next is ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch. Next is FETCH.
- Cycle counts with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
  - Each extra cycle with mem_ready=0 in a wait state adds exactly one cycle.
- Boundary conditions:
  - reset mid-instruction (any state) returns to FETCH on the next edge; no write strobe is issued in the reset cycle.
  - op is sampled only in DECODE and MEMADR; op changing in other states has no effect.
  - zero is ignored outside BEQ.
  - Unused state encodings go to FETCH with all enables 0.

Test Plan:
- Reset held 2 cycles, then released; mem_ready=1 -> cycle 0 is FETCH: ir_write=1, pc_write=1, alu_src_b=10, result_src=10; state reaches DECODE next cycle.
- op=0000011, mem_ready=1 -> sequence FETCH, DECODE, MEMADR, MEMREAD (adr_src=1), MEMWB (result_src=01, reg_write=1), then FETCH; 5 cycles total.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, then FETCH; reg_write never asserted.
- op=1100011, zero=1 in BEQ -> pc_write=1, alu_op=01. Repeat with zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- op=0110011, then op=0010011 -> EXECUTER gives alu_src_b=00 and EXECUTEI gives alu_src_b=01, both with alu_op=10; ALUWB follows with reg_write=1. op=1101111 -> JAL gives pc_write=1, then ALUWB.
- op=0000000 -> illegal_op pulses for 1 cycle in DECODE, then FETCH. Separately, reset asserted in MEMWRITE -> mem_write=0 in that cycle and FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences each instruction
// over 3-5 cycles, driving the datapath mux selects and write enables.
module multicycle_ctrl_fsm #(
    parameter bit USE_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal_op
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    state_t state, state_next, out_state;
    logic   rdy, pc_update, branch;

    assign rdy = mem_ready | ~USE_READY;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = rdy ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = rdy ? FETCH : MEMWRITE;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            JAL:      state_next = ALUWB;
            BEQ:      state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // While in reset the selects present FETCH values regardless of state.
    always_comb begin
        out_state  = reset ? FETCH : state;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (out_state)
            FETCH: begin
                ir_write   = rdy;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_op = 1'b0;
                    default:                                  illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: ;
        endcase
        // JAL is the only pc_update state not in a memory wait, so rdy is
        // bypassed there.
        pc_write = (pc_update & (rdy | (out_state == JAL))) | (branch & zero);
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle vector table plus a
// hand-driven lw with memory wait states to check cycle count.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [6:0] op;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.USE_READY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .illegal_op(illegal_op)
    );

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0000000;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, alu_op, reg_write, illegal_op}
    localparam logic [13:0] E_FETCH  = 14'b1_0_0_1_10_00_10_00_0_0;
    localparam logic [13:0] E_IDLE   = 14'b0_0_0_0_10_00_10_00_0_0;
    localparam logic [13:0] E_DEC    = 14'b0_0_0_0_00_01_01_00_0_0;
    localparam logic [13:0] E_ILL    = 14'b0_0_0_0_00_01_01_00_0_1;
    localparam logic [13:0] E_MADR   = 14'b0_0_0_0_00_10_01_00_0_0;
    localparam logic [13:0] E_MRD    = 14'b0_1_0_0_00_00_00_00_0_0;
    localparam logic [13:0] E_MWB    = 14'b0_0_0_0_01_00_00_00_1_0;
    localparam logic [13:0] E_MWR    = 14'b0_1_1_0_00_00_00_00_0_0;
    localparam logic [13:0] E_EXR    = 14'b0_0_0_0_00_10_00_10_0_0;
    localparam logic [13:0] E_EXI    = 14'b0_0_0_0_00_10_01_10_0_0;
    localparam logic [13:0] E_AWB    = 14'b0_0_0_0_00_00_00_00_1_0;
    localparam logic [13:0] E_JAL    = 14'b1_0_0_0_00_01_10_00_0_0;
    localparam logic [13:0] E_BEQ1   = 14'b1_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] E_BEQ0   = 14'b0_0_0_0_00_10_00_01_0_0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [13:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] outs();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_op, reg_write, illegal_op};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic z,
                       input logic rd, input logic [13:0] e, input string n);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc, waits;
        logic done;
        reset = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;

        // One row per clock cycle; inputs held for that cycle.
        add(1, LW,  0, 1, E_IDLE,  "reset0");
        add(1, LW,  0, 1, E_IDLE,  "reset1");
        add(0, LW,  0, 0, E_IDLE,  "fetch_wait");
        add(0, LW,  0, 1, E_FETCH, "lw_fetch");
        add(0, LW,  1, 1, E_DEC,   "lw_decode_zero_ignored");
        add(0, LW,  0, 1, E_MADR,  "lw_memadr");
        add(0, SW,  0, 1, E_MRD,   "lw_memread_op_change");
        add(0, SW,  0, 1, E_MWB,   "lw_memwb");
        add(0, SW,  0, 1, E_FETCH, "sw_fetch");
        add(0, SW,  0, 1, E_DEC,   "sw_decode");
        add(0, SW,  0, 1, E_MADR,  "sw_memadr");
        add(0, SW,  0, 0, E_MWR,   "sw_memwrite_w0");
        add(0, SW,  1, 0, E_MWR,   "sw_memwrite_w1");
        add(0, SW,  0, 0, E_MWR,   "sw_memwrite_w2");
        add(0, BQ,  0, 1, E_MWR,   "sw_memwrite_done");
        add(0, BQ,  0, 1, E_FETCH, "beq1_fetch");
        add(0, BQ,  0, 1, E_DEC,   "beq1_decode");
        add(0, BQ,  1, 0, E_BEQ1,  "beq_taken");
        add(0, BQ,  0, 1, E_FETCH, "beq0_fetch");
        add(0, BQ,  1, 1, E_DEC,   "beq0_decode");
        add(0, RT,  0, 1, E_BEQ0,  "beq_not_taken");
        add(0, RT,  0, 1, E_FETCH, "r_fetch");
        add(0, RT,  0, 1, E_DEC,   "r_decode");
        add(0, IT,  1, 1, E_EXR,   "r_execute");
        add(0, IT,  0, 1, E_AWB,   "r_aluwb");
        add(0, IT,  0, 1, E_FETCH, "i_fetch");
        add(0, IT,  0, 1, E_DEC,   "i_decode");
        add(0, BAD, 0, 1, E_EXI,   "i_execute_op_change");
        add(0, JL,  0, 1, E_AWB,   "i_aluwb");
        add(0, JL,  0, 1, E_FETCH, "jal_fetch");
        add(0, JL,  0, 1, E_DEC,   "jal_decode");
        add(0, JL,  0, 0, E_JAL,   "jal_no_rdy_gate");
        add(0, BAD, 0, 1, E_AWB,   "jal_aluwb");
        add(0, BAD, 0, 1, E_FETCH, "ill_fetch");
        add(0, BAD, 0, 1, E_ILL,   "ill_decode_pulse");
        add(0, SW,  0, 1, E_FETCH, "ill_back_to_fetch");
        add(0, SW,  0, 1, E_DEC,   "rst_decode");
        add(0, SW,  0, 1, E_MADR,  "rst_memadr");
        add(1, SW,  0, 1, E_IDLE,  "reset_in_memwrite");
        add(0, SW,  0, 1, E_FETCH, "fetch_after_reset");
        add(0, SW,  0, 1, E_DEC,   "decode_after_reset");

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op;
            zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            checks++;
            if (outs() !== vecs[i].exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", vecs[i].name, outs(), vecs[i].exp);
            end
        end

        // lw with two wait cycles in MEMREAD: 5 + 2 = 7 cycles FETCH to FETCH.
        @(negedge clk);
        reset = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;
        cyc = 0; waits = 0; done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ir_write !== 1'b1) begin
            errors++;
            $display("FAIL lw_wait_start: got ir_write=%b expected 1", ir_write);
        end
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            mem_ready = 1'b1;
            #1;
            if (adr_src && !mem_write && waits < 2) begin
                mem_ready = 1'b0;
                waits++;
            end
            #1;
            if (ir_write === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || cyc != 7) begin
            errors++;
            $display("FAIL lw_wait_cycles: got %0d cycles (done=%b) expected 7", cyc, done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
